// File: rtl/img_capture_sched.sv
// Capture/readout sequencer for ImgController: ping-pong RAM blocks, pixel-count check, retries.
// Optional capture-attempt timeout is enabled by defining IMGSCHED_TIMEOUT_EN.
module img_capture_sched #(
    parameter int unsigned ExpectedPixelCount = 2304*1296,
    parameter int unsigned PixelCountWidth    = 22,
    parameter int unsigned MaxRetries         = 2,
    parameter int unsigned TimeoutCycles      = 2_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_readout,
    input  logic                       req_thumb,
    input  logic                       req_skipCount,
    output logic                       ctrl_cmd_capture,
    output logic                       ctrl_cmd_readout,
    output logic                       ctrl_cmd_ramBlock,
    output logic                       ctrl_cmd_skipCount,
    output logic                       ctrl_cmd_thumb,
    input  logic                       ctrl_status_captureDone,
    input  logic [PixelCountWidth-1:0] ctrl_status_capturePixelCount,
    input  logic                       readout_done,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_ok,
    output logic [1:0]                 rsp_err,
    output logic                       rsp_ramBlock,
    output logic [1:0]                 rsp_attempts,
    output logic                       good_valid,
    output logic                       good_block
);
    typedef enum logic [2:0] {
        S_IDLE, S_CAP_ISSUE, S_CAP_WAIT, S_CHECK, S_RD_ISSUE, S_RD_WAIT, S_RSP
    } state_t;

    localparam logic [PixelCountWidth-1:0] ExpCount = PixelCountWidth'(ExpectedPixelCount);
    localparam logic [1:0] MaxRetriesW = 2'(MaxRetries);
    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrCount   = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;

    if (MaxRetries > 3) begin : g_bad_retries
        $error("MaxRetries must be in 0..3");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 1");
    end

    state_t                     state_q, state_d;
    logic                       target_q, target_d;
    logic [1:0]                 attempts_q, attempts_d;
    logic                       done_prev_q, done_prev_d;
    logic [PixelCountWidth-1:0] count_q, count_d;
    logic                       rd_q, rd_d;
    logic                       thumb_q, thumb_d;
    logic                       req_ready_q, req_ready_d;
    logic                       cmd_capture_q, cmd_capture_d;
    logic                       cmd_readout_q, cmd_readout_d;
    logic                       cmd_ram_q, cmd_ram_d;
    logic                       cmd_skip_q, cmd_skip_d;
    logic                       cmd_thumb_q, cmd_thumb_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       rsp_ok_q, rsp_ok_d;
    logic [1:0]                 rsp_err_q, rsp_err_d;
    logic                       rsp_ram_q, rsp_ram_d;
    logic [1:0]                 rsp_att_q, rsp_att_d;
    logic                       good_valid_q, good_valid_d;
    logic                       good_block_q, good_block_d;
    logic                       check_timeout;

`ifdef IMGSCHED_TIMEOUT_EN
    localparam int unsigned     TimerW   = $clog2(TimeoutCycles + 1);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TimeoutCycles);
    logic [TimerW-1:0]          timer_q, timer_d;
    logic                       timeout_q, timeout_d;
    assign check_timeout = timeout_q;
`else
    assign check_timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        attempts_d    = attempts_q;
        done_prev_d   = done_prev_q;
        count_d       = count_q;
        rd_d          = rd_q;
        thumb_d       = thumb_q;
        req_ready_d   = req_ready_q;
        cmd_capture_d = cmd_capture_q;
        cmd_readout_d = cmd_readout_q;
        cmd_ram_d     = cmd_ram_q;
        cmd_skip_d    = cmd_skip_q;
        cmd_thumb_d   = cmd_thumb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_ok_d      = rsp_ok_q;
        rsp_err_d     = rsp_err_q;
        rsp_ram_d     = rsp_ram_q;
        rsp_att_d     = rsp_att_q;
        good_valid_d  = good_valid_q;
        good_block_d  = good_block_q;
`ifdef IMGSCHED_TIMEOUT_EN
        timer_d       = timer_q;
        timeout_d     = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    rd_d        = req_readout;
                    thumb_d     = req_thumb;
                    cmd_skip_d  = req_skipCount;
                    // Write into the block not holding the last good image.
                    target_d    = good_valid_q ? ~good_block_q : 1'b0;
                    attempts_d  = 2'd0;
                    req_ready_d = 1'b0;
                    state_d     = S_CAP_ISSUE;
                end
            end
            S_CAP_ISSUE: begin
                cmd_ram_d     = target_q;
                done_prev_d   = ctrl_status_captureDone;
                cmd_capture_d = ~cmd_capture_q;
`ifdef IMGSCHED_TIMEOUT_EN
                timer_d       = '0;
                timeout_d     = 1'b0;
`endif
                state_d       = S_CAP_WAIT;
            end
            S_CAP_WAIT: begin
                if (ctrl_status_captureDone != done_prev_q) begin
                    count_d = ctrl_status_capturePixelCount;
                    state_d = S_CHECK;
                end
`ifdef IMGSCHED_TIMEOUT_EN
                else if (timer_q == TimerMax) begin
                    timeout_d = 1'b1;
                    state_d   = S_CHECK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            S_CHECK: begin
                if (!check_timeout && count_q == ExpCount) begin
                    good_block_d = target_q;
                    good_valid_d = 1'b1;
                    if (rd_q) begin
                        state_d = S_RD_ISSUE;
                    end else begin
                        rsp_ok_d  = 1'b1;
                        rsp_err_d = ErrNone;
                        rsp_ram_d = target_q;
                        rsp_att_d = attempts_q;
                        state_d   = S_RSP;
                    end
                end else if (attempts_q < MaxRetriesW) begin
                    attempts_d = attempts_q + 1'b1;
                    state_d    = S_CAP_ISSUE;
                end else begin
                    rsp_ok_d  = 1'b0;
                    rsp_err_d = check_timeout ? ErrTimeout : ErrCount;
                    rsp_ram_d = good_block_q;
                    rsp_att_d = attempts_q;
                    state_d   = S_RSP;
                end
            end
            S_RD_ISSUE: begin
                cmd_ram_d     = good_block_q;
                cmd_thumb_d   = thumb_q;
                cmd_readout_d = ~cmd_readout_q;
                state_d       = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (readout_done) begin
                    rsp_ok_d  = 1'b1;
                    rsp_err_d = ErrNone;
                    rsp_ram_d = good_block_q;
                    rsp_att_d = attempts_q;
                    state_d   = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        target_d_reg: begin
            target_q    <= target_d;
            attempts_q  <= attempts_d;
            done_prev_q <= done_prev_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            thumb_q     <= thumb_d;
        end
        if (rst) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            cmd_capture_q <= 1'b0;
            cmd_readout_q <= 1'b0;
            cmd_ram_q     <= 1'b0;
            cmd_skip_q    <= 1'b0;
            cmd_thumb_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_ok_q      <= 1'b0;
            rsp_err_q     <= 2'd0;
            rsp_ram_q     <= 1'b0;
            rsp_att_q     <= 2'd0;
            good_valid_q  <= 1'b0;
            good_block_q  <= 1'b0;
`ifdef IMGSCHED_TIMEOUT_EN
            timer_q       <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            cmd_capture_q <= cmd_capture_d;
            cmd_readout_q <= cmd_readout_d;
            cmd_ram_q     <= cmd_ram_d;
            cmd_skip_q    <= cmd_skip_d;
            cmd_thumb_q   <= cmd_thumb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_ok_q      <= rsp_ok_d;
            rsp_err_q     <= rsp_err_d;
            rsp_ram_q     <= rsp_ram_d;
            rsp_att_q     <= rsp_att_d;
            good_valid_q  <= good_valid_d;
            good_block_q  <= good_block_d;
`ifdef IMGSCHED_TIMEOUT_EN
            timer_q       <= timer_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign req_ready          = req_ready_q;
    assign ctrl_cmd_capture   = cmd_capture_q;
    assign ctrl_cmd_readout   = cmd_readout_q;
    assign ctrl_cmd_ramBlock  = cmd_ram_q;
    assign ctrl_cmd_skipCount = cmd_skip_q;
    assign ctrl_cmd_thumb     = cmd_thumb_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_ok             = rsp_ok_q;
    assign rsp_err            = rsp_err_q;
    assign rsp_ramBlock       = rsp_ram_q;
    assign rsp_attempts       = rsp_att_q;
    assign good_valid         = good_valid_q;
    assign good_block         = good_block_q;

endmodule
